// File: rtl/branch_cmp_pht.sv
// D-stage branch comparator with a 2-bit saturating-counter pattern history table.
// Optional build macro BRANCH_STATS_EN adds saturating resolved/mispredict counters.
module branch_cmp_pht #(
    parameter int DATA_W    = 32,
    parameter int PHT_DEPTH = 64,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       lookup_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [31:0]       res_pc,
    input  logic              res_pred,
    input  logic [DATA_W-1:0] cmp_in1,
    input  logic [DATA_W-1:0] cmp_in2,
    input  logic [2:0]        br_type,
    output logic              br_true,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BGEZ = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLEZ = 3'b011,
        BR_BGTZ = 3'b100,
        BR_BLTZ = 3'b101
    } br_type_e;

    logic [1:0]       r_pht [PHT_DEPTH];
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_br_true;
    logic             w_mispredict;
    logic             w_in1_neg;
    logic             w_in1_zero;
    logic             w_in_eq;
    logic             w_unused_pc_bits;

    // Word-aligned PCs: bits [1:0] and everything above the index never select an entry.
    assign w_rd_idx = lookup_pc[IDX_W+1:2];
    assign w_wr_idx = res_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                                res_pc[31:IDX_W+2], res_pc[1:0]};

    assign w_in1_neg  = cmp_in1[DATA_W-1];
    assign w_in1_zero = (cmp_in1 == '0);
    assign w_in_eq    = (cmp_in1 == cmp_in2);

    // NOTE: every variable in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_br_true = 1'b0;
        case (br_type)
            BR_BEQ:  w_br_true = w_in_eq;
            BR_BGEZ: w_br_true = ~w_in1_neg;
            BR_BNE:  w_br_true = ~w_in_eq;
            BR_BLEZ: w_br_true = w_in1_neg | w_in1_zero;
            BR_BGTZ: w_br_true = ~w_in1_neg & ~w_in1_zero;
            BR_BLTZ: w_br_true = w_in1_neg;
            default: w_br_true = 1'b0;
        endcase
    end

    assign w_mispredict = res_valid & (w_br_true ^ res_pred);

    assign br_true    = w_br_true;
    assign mispredict = w_mispredict;
    // Combinational read of the stored value: a same-cycle update is not bypassed.
    assign pred_taken = r_pht[w_rd_idx][1];

    // NOTE: the PHT is a flop array rather than a RAM because reset must set every entry in one
    // cycle; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                r_pht[i] <= 2'b01;
            end
        end else if (res_valid) begin
            if (w_br_true) begin
                if (r_pht[w_wr_idx] != 2'b11) r_pht[w_wr_idx] <= r_pht[w_wr_idx] + 2'd1;
            end else begin
                if (r_pht[w_wr_idx] != 2'b00) r_pht[w_wr_idx] <= r_pht[w_wr_idx] - 2'd1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] r_stat_branches;
    logic [STAT_W-1:0] r_stat_miss;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches <= '0;
            r_stat_miss     <= '0;
        end else begin
            if (res_valid && (r_stat_branches != '1)) r_stat_branches <= r_stat_branches + STAT_ONE;
            if (w_mispredict && (r_stat_miss != '1))  r_stat_miss     <= r_stat_miss + STAT_ONE;
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_miss     = r_stat_miss;
`else
    assign stat_branches = '0;
    assign stat_miss     = '0;
`endif

endmodule
